// File: rtl/riscv_pkg.sv
// Shared riscv definitions: base opcodes plus the GPIO bank register window
// and its address decoder.
package riscv_pkg;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    // GPIO byte offsets
    localparam logic [31:0] GPIO_DATA_OUT = 32'h00;
    localparam logic [31:0] GPIO_DIR      = 32'h04;
    localparam logic [31:0] GPIO_DATA_IN  = 32'h08;
    localparam logic [31:0] GPIO_SET      = 32'h0C;
    localparam logic [31:0] GPIO_CLR      = 32'h10;
    localparam logic [31:0] GPIO_EDGE     = 32'h14;
    localparam logic [31:0] GPIO_IRQ_MASK = 32'h18;

    typedef enum logic [2:0] {
        GR_DOUT, GR_DIR, GR_DIN, GR_SET, GR_CLR, GR_EDGE, GR_MASK, GR_NONE
    } gpio_reg_e;

    function automatic gpio_reg_e gpio_decode(input logic [31:0] off);
        case (off)
            GPIO_DATA_OUT: return GR_DOUT;
            GPIO_DIR:      return GR_DIR;
            GPIO_DATA_IN:  return GR_DIN;
            GPIO_SET:      return GR_SET;
            GPIO_CLR:      return GR_CLR;
            GPIO_EDGE:     return GR_EDGE;
            GPIO_IRQ_MASK: return GR_MASK;
            default:       return GR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser, WIDTH bits wide and SYNC_STAGES deep,
// all flops reset to 0.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else        r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/riscv_gpio_bank.sv
// Memory-mapped GPIO bank: direction, synchronised inputs, set/clear, edge status.
// Define RISCV_GPIO_IRQ_EN to add IRQ_MASK and the registered irq output.
module riscv_gpio_bank import riscv_pkg::*; #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               ADDR_W      = 5,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [WIDTH-1:0]  gpio_i,
    output logic [WIDTH-1:0]  gpio_o,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    logic [WIDTH-1:0] r_data_out, r_dir, r_prev, r_edge;
    logic [WIDTH-1:0] w_sync, w_edge, w_wd, w_clr, w_mask;
    logic [31:0]      r_rdata, w_rmux;
    logic             r_rvalid, w_wr, w_rd, w_unused_bits;
    gpio_reg_e        w_reg;

    assign w_wr  = sel & we;
    assign w_rd  = sel & ~we;
    assign w_reg = gpio_decode(32'(addr & ~ADDR_W'(3)));
    assign w_wd  = wdata[WIDTH-1:0];
    assign w_unused_bits = &{1'b0, wdata};

    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (gpio_i),
        .o_q   (w_sync)
    );

    // Any change of the synchronised sample is an edge; a same-cycle W1C loses to it.
    assign w_edge = w_sync ^ r_prev;
    assign w_clr  = (w_wr && w_reg == GR_EDGE) ? w_wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= OUT_RESET;
            r_dir      <= '0;
            r_prev     <= '0;
            r_edge     <= '0;
        end else begin
            r_prev <= w_sync;
            r_edge <= (r_edge & ~w_clr) | w_edge;
            if (w_wr) begin
                case (w_reg)
                    GR_DOUT: r_data_out <= w_wd;
                    GR_DIR:  r_dir      <= w_wd;
                    GR_SET:  r_data_out <= r_data_out | w_wd;
                    GR_CLR:  r_data_out <= r_data_out & ~w_wd;
                    default: ;
                endcase
            end
        end
    end

`ifdef RISCV_GPIO_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic             r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_reg == GR_MASK) r_mask <= w_wd;
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign irq    = r_irq;
`else
    assign w_mask = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        w_rmux = '0;
        case (w_reg)
            GR_DOUT: w_rmux = 32'(r_data_out);
            GR_DIR:  w_rmux = 32'(r_dir);
            GR_DIN:  w_rmux = 32'(w_sync);
            GR_EDGE: w_rmux = 32'(r_edge);
            GR_MASK: w_rmux = 32'(w_mask);
            default: w_rmux = '0;
        endcase
    end

    // rdata only moves on a read so it holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rmux;
        end
    end

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign gpio_o  = r_data_out;
    assign gpio_oe = r_dir;

endmodule

// File: tb/tb_riscv_gpio_bank.sv
// Directed bench for riscv_gpio_bank (WIDTH=8, SYNC_STAGES=2, OUT_RESET=8'hA5).
module tb_riscv_gpio_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel, we;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic        rvalid, irq;
    logic [7:0]  gpio_i, gpio_o, gpio_oe;

    int checks = 0;
    int errors = 0;

    riscv_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .ADDR_W(5), .OUT_RESET(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        sel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_i = 8'h00;
        tick(); tick();
        check("rst_gpio_o", 32'(gpio_o), 32'hA5);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        rst_n = 1'b1;
        tick();

        bus_read(5'h00);
        check("rd_dout_rst", rdata, 32'h000000A5);
        check("rd_dout_rst_vld", 32'(rvalid), 32'h1);
        tick();
        check("rvalid_drop", 32'(rvalid), 32'h0);
        check("rdata_hold", rdata, 32'h000000A5);

        bus_write(5'h04, 32'hFFFF_FF0F);
        bus_write(5'h00, 32'h0000_003C);
        bus_write(5'h0C, 32'h0000_0080);
        check("wr_no_rvalid", 32'(rvalid), 32'h0);
        bus_write(5'h10, 32'h0000_0004);
        check("set_clr_gpio_o", 32'(gpio_o), 32'hB8);
        check("dir_gpio_oe", 32'(gpio_oe), 32'h0F);
        bus_read(5'h00);
        check("rd_dout", rdata, 32'h000000B8);
        bus_read(5'h04);
        check("rd_dir_zext", rdata, 32'h0000000F);
        bus_read(5'h0C);
        check("rd_set_wo", rdata, 32'h0);
        bus_write(5'h08, 32'hFF);
        bus_read(5'h00);
        check("ro_write_ignored", rdata, 32'h000000B8);

        // Input synchroniser latency
        gpio_i = 8'h41;
        tick();
        bus_read(5'h08);
        check("din_early", rdata, 32'h0);
        bus_read(5'h08);
        check("din_ready", rdata, 32'h41);
        tick(); tick();
        bus_write(5'h14, 32'hFF);
        bus_read(5'h14);
        check("edge_cleared", rdata, 32'h0);

`ifdef RISCV_GPIO_IRQ_EN
        bus_write(5'h18, 32'h08);
`endif
        // Rising edge on pin 3
        gpio_i = 8'h49;
        tick(); tick(); tick();
        check("irq_not_yet", 32'(irq), 32'h0);
        tick();
`ifdef RISCV_GPIO_IRQ_EN
        check("irq_rise", 32'(irq), 32'h1);
`else
        check("irq_tied", 32'(irq), 32'h0);
`endif
        bus_read(5'h14);
        check("edge_pin3", rdata, 32'h08);

        // Falling edge on pin 3 lands on the same edge as the W1C
        gpio_i = 8'h41;
        tick(); tick();
        bus_write(5'h14, 32'h08);
        bus_read(5'h14);
        check("w1c_edge_wins", rdata, 32'h08);
        bus_write(5'h14, 32'h08);
        bus_read(5'h14);
        check("w1c_clear", rdata, 32'h0);
        check("irq_fall", 32'(irq), 32'h0);
        bus_read(5'h18);
`ifdef RISCV_GPIO_IRQ_EN
        check("rd_mask", rdata, 32'h08);
`else
        check("rd_mask_absent", rdata, 32'h0);
`endif

        // Reset while a read is in flight
        bus_read(5'h00);
        sel = 1'b1; we = 1'b0; addr = 5'h00;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'h0);
        check("midrst_gpio_o", 32'(gpio_o), 32'hA5);
        check("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        tick();
        sel = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_rvalid", 32'(rvalid), 32'h0);
        bus_read(5'h1C);
        check("rd_unmapped", rdata, 32'h0);
        check("rd_unmapped_vld", 32'(rvalid), 32'h1);
        bus_read(5'h04);
        check("rd_dir_after_rst", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
